// File: rtl/nf_dm_responder.sv
// Responder end of the CPU data-memory req/ack handshake: word-addressed RAM,
// programmable wait states, and error flagging for out-of-range or misaligned accesses.
module nf_dm_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] addr_dm,
    input  logic        we_dm,
    input  logic [31:0] wd_dm,
    input  logic        req_dm,
    output logic        req_ack_dm,
    output logic [31:0] rd_dm,
    output logic        err_dm,
    output logic        busy
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_next_cnt;
    logic [IW-1:0]   r_idx;
    logic            r_we;
    logic            r_err;
    logic [31:0]     r_wd;
    logic [31:0]     r_mem [DEPTH];

    logic            w_capture;
    logic            w_access;
    logic            w_in_err;
    logic [IW-1:0]   w_in_idx;
    logic [IW-1:0]   w_acc_idx;
    logic            w_acc_we;
    logic            w_acc_err;
    logic [31:0]     w_acc_wd;

    // Range is checked on the full word index before truncating, so there is no wrap.
    assign w_in_err  = ({2'b00, addr_dm[31:2]} >= 32'(DEPTH)) || (addr_dm[1:0] != 2'b00);
    assign w_in_idx  = addr_dm[IW+1:2];
    assign w_capture = (r_state == S_IDLE) && req_dm;

    // With zero wait states the access happens on the capture edge, straight from the inputs.
    assign w_acc_idx = (r_state == S_IDLE) ? w_in_idx : r_idx;
    assign w_acc_we  = (r_state == S_IDLE) ? we_dm    : r_we;
    assign w_acc_err = (r_state == S_IDLE) ? w_in_err : r_err;
    assign w_acc_wd  = (r_state == S_IDLE) ? wd_dm    : r_wd;

    assign busy = (r_state != S_IDLE);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_access     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_dm) begin
                    if (WAIT_CYCLES == 0) begin
                        w_access     = 1'b1;
                        w_next_state = S_ACK;
                    end else begin
                        w_next_cnt   = CW'(WAIT_CYCLES - 1);
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_next_cnt = r_cnt - 1'b1;
                end else begin
                    w_access     = 1'b1;
                    w_next_state = S_ACK;
                end
            end
            S_ACK:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_we       <= 1'b0;
            r_wd       <= '0;
            r_err      <= 1'b0;
            req_ack_dm <= 1'b0;
            rd_dm      <= '0;
            err_dm     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            req_ack_dm <= w_access;
            err_dm     <= w_access & w_acc_err;
            if (w_capture) begin
                r_idx <= w_in_idx;
                r_we  <= we_dm;
                r_wd  <= wd_dm;
                r_err <= w_in_err;
            end
            if (w_access) begin
                if (w_acc_we)       rd_dm <= '0;
                else if (w_acc_err) rd_dm <= ERR_DATA;
                else                rd_dm <= r_mem[w_acc_idx];
            end
        end
    end

    // NOTE: the RAM has no reset so it maps onto block memory; contents survive resetn.
    always_ff @(posedge clk) begin
        if (resetn && w_access && w_acc_we && !w_acc_err) begin
            r_mem[w_acc_idx] <= w_acc_wd;
        end
    end

endmodule
